// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- command-request handshake between a controller and the
// PS/2 host transmitter.
//   tx_data  [7:0]  command byte, captured with tx_start
//   tx_start        one-cycle send request
//   tx_busy         frame in flight
//   tx_done         one-cycle pulse: frame sent and acknowledged
//   tx_err          one-cycle pulse: timeout or missing acknowledge
// master = requesting controller, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, then shifts out an 8-bit
// command (LSB first), odd parity and stop bit on the device's clock, and
// checks the device acknowledge.
//   clk, reset          system clock, synchronous active-high reset
//   bus (slave)         tx_data/tx_start request, tx_busy/tx_done/tx_err status
//   kbdclk_in/kbddat_in sensed PS/2 lines (asynchronous)
//   kbdclk_oe/kbddat_oe open-drain pull-low enables (registered)
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         kbdclk_in,
  input  logic         kbddat_in,
  output logic         kbdclk_oe,
  output logic         kbddat_oe
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INHIBIT = 3'd1;
  localparam logic [2:0] REQ     = 3'd2;
  localparam logic [2:0] BITS    = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [7:0]    shreg;
  logic          parity;
  logic [3:0]    bitcnt;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic          busy;
  logic          done;
  logic          err;

  // Two-flop synchronizers plus a history flop for edge detection. All reset
  // high (idle line) so leaving reset never looks like a falling edge.
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], kbdclk_in};
      dat_sync <= {dat_sync[0], kbddat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      kbdclk_oe <= 1'b0;
      kbddat_oe <= 1'b0;
      shreg     <= '0;
      parity    <= 1'b0;
      bitcnt    <= '0;
      icnt      <= '0;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE && tcnt == TLAST) begin
        state     <= IDLE;
        kbdclk_oe <= 1'b0;
        kbddat_oe <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
      end else begin
        if (state != IDLE) tcnt <= tcnt + TW'(1);
        case (state)
          IDLE: begin
            kbdclk_oe <= 1'b0;
            kbddat_oe <= 1'b0;
            // done/err high means this is the pulse cycle: requests are dropped.
            if (bus.tx_start && !done && !err) begin
              shreg     <= bus.tx_data;
              parity    <= ~^bus.tx_data;
              bitcnt    <= '0;
              icnt      <= '0;
              tcnt      <= '0;
              busy      <= 1'b1;
              kbdclk_oe <= 1'b1;
              state     <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (icnt == ILAST) begin
              kbddat_oe <= 1'b1;
              state     <= REQ;
            end else begin
              icnt <= icnt + IW'(1);
            end
          end
          REQ: begin
            kbdclk_oe <= 1'b0;
            state     <= BITS;
          end
          BITS: begin
            // bitcnt holds the number of edges seen so far (0..9).
            if (fall) begin
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt < 4'd8) begin
                kbddat_oe <= ~shreg[bitcnt[2:0]];
              end else if (bitcnt == 4'd8) begin
                kbddat_oe <= ~parity;
              end else begin
                kbddat_oe <= 1'b0;
                state     <= ACK;
              end
            end
          end
          ACK: begin
            if (fall) begin
              if (!dat_sync[1]) begin
                state <= RELEASE;
              end else begin
                busy  <= 1'b0;
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          RELEASE: begin
            if (clk_sync[1] && dat_sync[1]) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: begin
            kbdclk_oe <= 1'b0;
            kbddat_oe <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_busy = busy;
  assign bus.tx_done = done;
  assign bus.tx_err  = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HALF = 8;

  localparam logic [1:0] R_DONE = 2'b10;
  localparam logic [1:0] R_ERR  = 2'b01;

  localparam int MODE_ACK   = 0;
  localparam int MODE_NACK  = 1;
  localparam int MODE_NOCLK = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic kbdclk_in, kbddat_in, kbdclk_oe, kbddat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .kbdclk_in(kbdclk_in),
    .kbddat_in(kbddat_in),
    .kbdclk_oe(kbdclk_oe),
    .kbddat_oe(kbddat_oe)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND lines with external pull-ups.
  assign kbdclk_in = ~(kbdclk_oe | dev_clk_low);
  assign kbddat_in = ~(kbddat_oe | dev_dat_low);

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int dev_mode  = MODE_ACK;
  int dev_edges = 0;
  logic dev_active = 1'b0;
  logic dev_abort  = 1'b0;

  logic [1:0] exp_res[$];
  logic [9:0] exp_frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/err pulse is matched against the scoreboard.
  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (bus.tx_done || bus.tx_err) begin
        pulse_cnt++;
        check("pulse_expected", exp_res.size() != 0, 1);
        if (exp_res.size() != 0) begin
          e = exp_res.pop_front();
          check("result", {bus.tx_done, bus.tx_err}, e);
        end
        check("busy_low_at_pulse", bus.tx_busy, 0);
      end
    end
  end

  // Device model: clocks the frame in, samples data at each rising edge,
  // then acknowledges (or not) on the 11th clock.
  initial begin : device
    logic prev_oe;
    logic [9:0] cap;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_oe && !kbdclk_oe && kbddat_oe && dev_mode != MODE_NOCLK) begin
        dev_active = 1'b1;
        dev_edges = 0;
        cap = '0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
          if (dev_abort) break;
          dev_clk_low = 1'b1;
          dev_edges = b + 1;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          cap[b] = kbddat_in;
          repeat (HALF) @(negedge clk);
          if (!dev_abort) check("bit_stable_high", kbddat_in, cap[b]);
        end
        if (!dev_abort) begin
          if (dev_mode == MODE_ACK) dev_dat_low = 1'b1;
          repeat (2) @(negedge clk);
          dev_clk_low = 1'b1;
          dev_edges = 11;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (2) @(negedge clk);
          dev_dat_low = 1'b0;
          check("frame_expected", exp_frame.size() != 0, 1);
          if (exp_frame.size() != 0) check("frame", cap, exp_frame.pop_front());
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge clk);
        dev_active = 1'b0;
      end
      prev_oe = kbdclk_oe;
    end
  end

  task automatic start_tx(input logic [7:0] d, input logic [9:0] frame,
                          input logic want_frame, input logic [1:0] res);
    if (want_frame) exp_frame.push_back(frame);
    exp_res.push_back(res);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_result(input int unsigned budget);
    int start;
    int unsigned n;
    start = pulse_cnt;
    n = 0;
    while (pulse_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("result_in_time", pulse_cnt != start, 1);
    n = 0;
    while (dev_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("device_idle", dev_active, 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame vectors are {stop, parity, data}; parity is odd parity of data.
  initial begin : driver
    int unsigned n;
    logic [7:0]  vd[2];
    logic [9:0]  vf[2];
    vd[0] = 8'h01; vf[0] = 10'h201;  // one bit set -> parity 0
    vd[1] = 8'h00; vf[1] = 10'h300;  // no bits set -> parity 1

    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", kbdclk_oe, 0);
    check("rst_dat_oe", kbddat_oe, 0);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_err", bus.tx_err, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED = 1110_1101, six ones -> parity 1
    start_tx(8'hED, 10'h3ED, 1'b1, R_DONE);
    check("busy_after_start", bus.tx_busy, 1);
    n = 0;
    while (kbdclk_oe && !kbddat_oe && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_bit_clk_held", {kbdclk_oe, kbddat_oe}, 2'b11);
    @(negedge clk);
    check("start_bit_clk_released", {kbdclk_oe, kbddat_oe}, 2'b01);
    wait_result(800);

    for (int i = 0; i < 2; i++) begin
      start_tx(vd[i], vf[i], 1'b1, R_DONE);
      wait_result(800);
    end

    // Device never clocks: timeout
    dev_mode = MODE_NOCLK;
    start_tx(8'hA5, 10'h000, 1'b0, R_ERR);
    n = 0;
    while (!bus.tx_err && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", (n >= TMO - 2) && (n <= TMO + 2), 1);
    @(negedge clk);
    check("timeout_oe_released", {kbdclk_oe, kbddat_oe}, 2'b00);
    check("timeout_err_one_cycle", bus.tx_err, 0);
    check("timeout_busy", bus.tx_busy, 0);
    dev_mode = MODE_ACK;
    repeat (5) @(negedge clk);

    // Missing acknowledge; 0x3C has four ones -> parity 1
    dev_mode = MODE_NACK;
    start_tx(8'h3C, 10'h33C, 1'b1, R_ERR);
    wait_result(800);
    dev_mode = MODE_ACK;
    start_tx(8'hFF, 10'h3FF, 1'b1, R_DONE);
    wait_result(800);

    // Request while busy is dropped; frame keeps 0xED
    start_tx(8'hED, 10'h3ED, 1'b1, R_DONE);
    n = 0;
    while (dev_edges != 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_edge4", dev_edges, 4);
    @(negedge clk);
    bus.tx_data  = 8'h55;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_result(800);
    repeat (5) @(negedge clk);
    check("no_extra_frame", bus.tx_busy, 0);

    // Reset mid-frame after edge 5
    start_tx(8'hED, 10'h3ED, 1'b1, R_DONE);
    n = 0;
    while (dev_edges != 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_edge5", dev_edges, 5);
    repeat (4) @(negedge clk);
    void'(exp_res.pop_back());
    void'(exp_frame.pop_back());
    dev_abort = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_oe", {kbdclk_oe, kbddat_oe}, 2'b00);
    check("midreset_busy", bus.tx_busy, 0);
    check("midreset_pulses", {bus.tx_done, bus.tx_err}, 2'b00);
    n = 0;
    while (dev_active && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("device_aborted", dev_active, 0);
    dev_abort = 1'b0;
    repeat (5) @(negedge clk);
    start_tx(8'hED, 10'h3ED, 1'b1, R_DONE);
    wait_result(800);

    repeat (10) @(negedge clk);
    check("results_drained", exp_res.size(), 0);
    check("frames_drained", exp_frame.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001: Parameter INHIBIT_CYCLES, default 10000; clk cycles the host holds kbdclk low before the start bit (100 us at 100 MHz).
- REQ-002: Parameter TIMEOUT_CYCLES, default 2000000; maximum clk cycles from leaving IDLE to frame completion (20 ms at 100 MHz).
- REQ-003: clk  input  1  system clock; one clock domain; all state updates on posedge clk.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: tx_data  input  8  command byte to send to the keyboard, e.g. 0xED (set LEDs) or 0xFF (reset).
- REQ-006: tx_start  input  1  one-cycle request; tx_data captured in the same cycle.
- REQ-007: kbdclk_in  input  1  sensed PS/2 clock line, asynchronous to clk.
- REQ-008: kbddat_in  input  1  sensed PS/2 data line, asynchronous to clk.
- REQ-009: kbdclk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open drain, pulled up externally).
- REQ-010: kbddat_oe  output  1  1 = drive PS/2 data low; 0 = release.
- REQ-011: tx_busy  output  1  high from accepted tx_start until the cycle tx_done or tx_err pulses.
- REQ-012: tx_done  output  1  one-cycle pulse: frame sent and ACK received.
- REQ-013: tx_err  output  1  one-cycle pulse: timeout or missing ACK; never pulses in the same cycle as tx_done.

Function
- REQ-014: kbdclk_in and kbddat_in each pass through a 2-flop synchronizer; a device falling edge is synchronized clock 1 in the previous cycle and 0 in the current cycle.
- REQ-015: States: IDLE, INHIBIT, REQ, BITS, ACK, RELEASE.
- REQ-016: IDLE: both oe = 0, tx_busy = 0; tx_start = 1 latches tx_data, computes the odd-parity bit (XNOR of the 8 bits), clears the bit counter and timeout counter, and moves to INHIBIT.
- REQ-017: INHIBIT: kbdclk_oe = 1, kbddat_oe = 0 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ-018: REQ: kbddat_oe = 1 (start bit 0) for 1 cycle with kbdclk_oe still 1; then kbdclk_oe = 0 and move to BITS.
- REQ-019: In BITS, each synchronized device falling edge advances the counter (1..10) and updates the data line.
  - Edges 1-8: kbddat_oe = NOT tx_data[edge-1], LSB first.
  - Edge 9: kbddat_oe = NOT parity.
  - Edge 10: kbddat_oe = 0 (stop bit, line released); move to ACK.
- REQ-020: ACK: on the next device falling edge (11th), sample synchronized kbddat.
  - 0: move to RELEASE.
  - 1: pulse tx_err and return to IDLE.
- REQ-021: RELEASE: wait until synchronized kbdclk = 1 and kbddat = 1 in the same cycle, then pulse tx_done and return to IDLE.
- REQ-022: The timeout counter increments every cycle outside IDLE; reaching TIMEOUT_CYCLES in any state forces both oe = 0, pulses tx_err, and returns to IDLE.
- REQ-023: tx_start while tx_busy = 1 is ignored; tx_data changes while busy do not alter the frame in flight.
- REQ-024: Data-line changes happen only in the cycle after a detected falling edge, never on a rising edge.
- REQ-025: tx_start in the same cycle as tx_done/tx_err is ignored; a new request is accepted only from IDLE the following cycle.
- REQ-026: kbdclk_oe and kbddat_oe are registered outputs with no combinational path from inputs.

Reset
- REQ-027: reset = 1 on a clock edge forces state IDLE, both oe = 0, tx_busy/tx_done/tx_err = 0, and clears all counters, effective the next cycle.
- REQ-028: reset asserted mid-frame releases both PS/2 lines within one cycle and emits no tx_done or tx_err pulse.
- REQ-029: Synchronizer flops reset to 1 (idle-high line) so no false falling edge follows reset.

Verification
- REQ-030: tx_start with tx_data = 0xED, device model ACKs.
  - Required: kbdclk_oe high exactly INHIBIT_CYCLES, then start bit.
  - Data line at the model's rising edges reads 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - tx_done pulses once after the lines return high; tx_busy falls the same cycle.
- REQ-031: tx_data = 0x01 -> parity bit 0; tx_data = 0x00 -> parity bit 1; each frame ends in tx_done.
- REQ-032: Device model never clocks -> tx_err pulses at TIMEOUT_CYCLES after tx_start (±2 cycles); both oe = 0 afterwards; tx_done stays 0.
- REQ-033: Device model leaves data high at the 11th edge -> tx_err pulses once, no tx_done; the next tx_start (0xFF) completes normally.
- REQ-034: tx_start = 0x55 at edge 4 of a frame carrying 0xED -> ignored; the frame still carries 0xED; exactly one tx_done.
- REQ-035: reset pulsed during BITS (after edge 5) -> next cycle both oe = 0 and tx_busy = 0, no pulses; a subsequent 0xED frame completes.
